// File: rtl/t10_disp_pkg.sv
// Shared types and ASCII constants for the word-guess history display.
package t10_disp_pkg;

    // Game status; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_WIN  = 2'd1,
        ST_LOSE = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BLANK = 8'h5F;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/t10_guess_match.sv
// DEPTH-way comparator: flags when the key equals any occupied history slot.
// Empty slots never match, so a guess of the blank character is still accepted.
module t10_guess_match #(
    parameter int DEPTH = 10
) (
    input  logic [DEPTH-1:0][7:0] hist_i,
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [7:0]            key_i,
    output logic                  hit_o
);

    // OR-reduce the per-slot equality, with every slot compared on all 8 bits.
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && (hist_i[i] == key_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t10_guess_history_disp.sv
// Guess history, wrong-guess counter and PLAY/WIN/LOSE tracking, packed into
// two ASCII rows for the LCD controller.
//
// Handshake: ready is a single-cycle strobe that qualifies msg and correct in
// that same cycle. There is no back-pressure; a strobe is either accepted,
// flagged as a duplicate, or ignored (game over / gameEnd) in that cycle.
module t10_guess_history_disp
    import t10_disp_pkg::*;
#(
    parameter int         ROW_CHARS = 16,
    parameter int         DEPTH     = 10,
    parameter int         MAX_WRONG = 6,
    parameter logic [7:0] BLANK     = ASCII_BLANK
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   ready,
    input  logic [7:0]             msg,
    input  logic                   correct,
    input  logic                   win,
    input  logic                   gameEnd,
    output logic [8*ROW_CHARS-1:0] row1,
    output logic [8*ROW_CHARS-1:0] row2,
    output logic [3:0]             wrong_cnt,
    output logic                   dup,
    output logic [1:0]             state
);

    localparam int         PAD     = (ROW_CHARS - DEPTH) / 2;
    localparam logic [3:0] WRONG_MAX = 4'(MAX_WRONG);

    logic [DEPTH-1:0][7:0] hist_q, hist_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [7:0]            last_q, last_d;
    logic [3:0]            wrong_q, wrong_d;
    logic                  dup_q, dup_d;
    state_e                state_q, state_d;
    logic                  hit;

    t10_guess_match #(.DEPTH(DEPTH)) u_match (
        .hist_i  (hist_q),
        .valid_i (valid_q),
        .key_i   (msg),
        .hit_o   (hit)
    );

    // Register bank; the async reset and gameEnd produce the same cleared image.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hist_q  <= {DEPTH{BLANK}};
            valid_q <= '0;
            last_q  <= ASCII_SPACE;
            wrong_q <= 4'd0;
            dup_q   <= 1'b0;
            state_q <= ST_PLAY;
        end else begin
            hist_q  <= hist_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wrong_q <= wrong_d;
            dup_q   <= dup_d;
            state_q <= state_d;
        end
    end

    // Next state: clear, accept/shift, duplicate flag, and status transitions
    // judged on the post-update counter so the deciding guess ends play at once.
    always_comb begin
        hist_d  = hist_q;
        valid_d = valid_q;
        last_d  = last_q;
        wrong_d = wrong_q;
        dup_d   = 1'b0;
        state_d = state_q;
        if (gameEnd) begin
            hist_d  = {DEPTH{BLANK}};
            valid_d = '0;
            last_d  = ASCII_SPACE;
            wrong_d = 4'd0;
            state_d = ST_PLAY;
        end else if (state_q == ST_PLAY) begin
            if (ready) begin
                if (hit) begin
                    dup_d = 1'b1;
                end else begin
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        hist_d[i]  = hist_q[i-1];
                        valid_d[i] = valid_q[i-1];
                    end
                    hist_d[0]  = msg;
                    valid_d[0] = 1'b1;
                    last_d     = msg;
                    if (!correct && (wrong_q != WRONG_MAX)) begin
                        wrong_d = wrong_q + 4'd1;
                    end
                end
            end
            if (win) begin
                state_d = ST_WIN;
            end else if (wrong_d == WRONG_MAX) begin
                state_d = ST_LOSE;
            end
        end
    end

    // Row packing; character 0 sits in the most significant byte.
    always_comb begin
        row1 = {ROW_CHARS{ASCII_SPACE}};
        row2 = {ROW_CHARS{ASCII_SPACE}};
        case (state_q)
            ST_WIN:  row1[8*ROW_CHARS-1 -: 8] = ASCII_W;
            ST_LOSE: row1[8*ROW_CHARS-1 -: 8] = ASCII_L;
            default: row1[8*ROW_CHARS-1 -: 8] = ASCII_QMARK;
        endcase
        row1[8*(ROW_CHARS - ROW_CHARS/2)-1 -: 8] = last_q;
        row1[7:0] = ASCII_ZERO + {4'd0, wrong_q};
        for (int i = 0; i < DEPTH; i++) begin
            row2[8*(ROW_CHARS - PAD - i)-1 -: 8] = hist_q[i];
        end
    end

    assign wrong_cnt = wrong_q;
    assign dup       = dup_q;
    assign state     = state_q;

endmodule

// File: tb/tb_t10_guess_history_disp.sv
module tb_t10_guess_history_disp;

    localparam int ROW_CHARS = 16;
    localparam int DEPTH     = 10;
    localparam int MAX_WRONG = 6;
    localparam int PAD       = (ROW_CHARS - DEPTH) / 2;

    logic         clk = 1'b0;
    logic         nRst;
    logic         ready;
    logic [7:0]   msg;
    logic         correct;
    logic         win;
    logic         gameEnd;
    logic [127:0] row1;
    logic [127:0] row2;
    logic [3:0]   wrong_cnt;
    logic         dup;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    t10_guess_history_disp #(
        .ROW_CHARS (ROW_CHARS),
        .DEPTH     (DEPTH),
        .MAX_WRONG (MAX_WRONG),
        .BLANK     (8'h5F)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .ready     (ready),
        .msg       (msg),
        .correct   (correct),
        .win       (win),
        .gameEnd   (gameEnd),
        .row1      (row1),
        .row2      (row2),
        .wrong_cnt (wrong_cnt),
        .dup       (dup),
        .state     (state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_hist[$];   // newest guess at index 0
    logic [7:0] m_last;
    int         m_wrong;
    bit         m_dup;
    int         m_state;     // 0 play, 1 win, 2 lose

    task automatic m_clear();
        m_hist.delete();
        m_last  = 8'h20;
        m_wrong = 0;
        m_dup   = 1'b0;
        m_state = 0;
    endtask

    function automatic bit m_seen(input logic [7:0] c);
        foreach (m_hist[i]) if (m_hist[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst || gameEnd) begin
            m_clear();
        end else begin
            m_dup = 1'b0;
            if (m_state == 0) begin
                if (ready) begin
                    if (m_seen(msg)) begin
                        m_dup = 1'b1;
                    end else begin
                        m_hist.push_front(msg);
                        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
                        m_last = msg;
                        if (!correct && m_wrong < MAX_WRONG) m_wrong++;
                    end
                end
                if (win) m_state = 1;
                else if (m_wrong == MAX_WRONG) m_state = 2;
            end
        end
    end

    function automatic logic [127:0] exp_row1();
        logic [127:0] r = '0;
        logic [7:0]   c;
        for (int i = 0; i < ROW_CHARS; i++) begin
            if (i == 0) c = (m_state == 0) ? 8'h3F : (m_state == 1) ? 8'h57 : 8'h4C;
            else if (i == ROW_CHARS / 2) c = m_last;
            else if (i == ROW_CHARS - 1) c = 8'(8'h30 + m_wrong);
            else c = 8'h20;
            r = {r[119:0], c};
        end
        return r;
    endfunction

    function automatic logic [127:0] exp_row2();
        logic [127:0] r = '0;
        logic [7:0]   c;
        int           s;
        for (int i = 0; i < ROW_CHARS; i++) begin
            s = i - PAD;
            if (s < 0 || s >= DEPTH) c = 8'h20;
            else if (s < m_hist.size()) c = m_hist[s];
            else c = 8'h5F;
            r = {r[119:0], c};
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("row1", row1, exp_row1());
            chk("row2", row2, exp_row2());
            chk("wrong_cnt", {124'd0, wrong_cnt}, 128'(m_wrong));
            chk("dup", {127'd0, dup}, {127'd0, m_dup});
            chk("state", {126'd0, state}, 128'(m_state));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit r, input logic [7:0] m, input bit c, input bit w, input bit g);
        ready = r; msg = m; correct = c; win = w; gameEnd = g;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] ch;
        m_clear();
        nRst = 1'b0; ready = 1'b0; msg = 8'h00; correct = 1'b0; win = 1'b0; gameEnd = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        #1;
        // 1. reset image
        chk("rst_row2", row2, "   __________   ");
        chk("rst_row1", row1, "?              0");
        nRst = 1'b1;
        idle();

        // 2. one right, one wrong
        cyc(1'b1, "A", 1'b1, 1'b0, 1'b0);
        cyc(1'b1, "B", 1'b0, 1'b0, 1'b0);
        chk("t2_row2", row2, "   BA________   ");
        chk("t2_wrong", {124'd0, wrong_cnt}, 128'd1);

        // 3. repeated letter
        cyc(1'b1, "A", 1'b1, 1'b0, 1'b0);
        chk("t3_dup", {127'd0, dup}, 128'd1);
        chk("t3_row2", row2, "   BA________   ");
        idle();
        chk("t3_dup_clr", {127'd0, dup}, 128'd0);

        // 4. overflow drops the oldest
        for (int k = 0; k < 10; k++) begin
            ch = 8'h43 + 8'(k);
            cyc(1'b1, ch, 1'b1, 1'b0, 1'b0);
        end
        chk("t4_row2", row2, "   LKJIHGFEDC   ");
        cyc(1'b1, "A", 1'b1, 1'b0, 1'b0);
        chk("t4_nodup", {127'd0, dup}, 128'd0);
        chk("t4_row2b", row2, "   ALKJIHGFED   ");

        // 5. six wrong guesses -> LOSE, then frozen
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            ch = 8'h4D + 8'(k);
            cyc(1'b1, ch, 1'b0, 1'b0, 1'b0);
        end
        chk("t5_state", {126'd0, state}, 128'd2);
        chk("t5_row1", row1, "L       R      6");
        cyc(1'b1, "S", 1'b0, 1'b0, 1'b0);
        chk("t5_row1_hold", row1, "L       R      6");
        chk("t5_row2_hold", row2, "   RQPONM____   ");

        // 6. win beats the simultaneous sixth wrong guess; gameEnd beats ready
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            ch = 8'h4D + 8'(k);
            cyc(1'b1, ch, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, "R", 1'b0, 1'b1, 1'b0);
        chk("t6_state", {126'd0, state}, 128'd1);
        chk("t6_wrong", {124'd0, wrong_cnt}, 128'd6);
        cyc(1'b1, "Z", 1'b0, 1'b1, 1'b1);
        chk("t6_row2", row2, "   __________   ");
        chk("t6_row1", row1, "?              0");

        // randomized phase, small alphabet (with lowercase) to provoke repeats
        for (int n = 0; n < 3000; n++) begin
            ch = (($urandom_range(0, 7) == 0) ? 8'h61 : 8'h41) + 8'($urandom_range(0, 11));
            cyc(1'($urandom_range(0, 1)), ch, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 40) == 0), ($urandom_range(0, 60) == 0));
            if (n == 1500) begin
                #2 nRst = 1'b0;
                #2 nRst = 1'b1;
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
